regfile_write_decode: RTL and testbench

Architectural register file for the pipelined CPU: 32 × 64-bit registers with one write port and two read ports. The block is the inverse of the read-side selection network. A 5-bit write address is decoded into one-hot write enables that steer WriteData into exactly one register. It sits between the write-back stage (write port) and the decode stage (read ports), and supplies same-cycle write-to-read bypass so decode never reads a stale value.

---
 rtl/regfile_write_decode.sv | 96 +++++++++
 tb/tb_regfile_write_decode.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_decode.sv
// -----------------------------------------------------------------------------
// regfile_write_decode
//   Architectural register file: 32 x WIDTH registers, one write port and two
//   combinational read ports. The write address is decoded into one-hot
//   enables that steer WriteData into a single register. X31 is hardwired to
//   zero. A same-cycle write-to-read bypass makes a value being written
//   visible on a matching read port before the clock edge.
//
// Ports
//   clk           : rising-edge clock, all writes happen on this edge
//   reset_n       : asynchronous active-low reset, clears every register,
//                   blocks writes and forces both read ports to zero
//   RegWrite      : write enable from write-back
//   WriteRegister : destination register address
//   WriteData     : data to write
//   ReadRegister1 : read port 1 address
//   ReadRegister2 : read port 2 address
//   ReadData1     : read port 1 data (combinational)
//   ReadData2     : read port 2 data (combinational)
// -----------------------------------------------------------------------------
module regfile_write_decode #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             RegWrite,
    input  logic [4:0]       WriteRegister,
    input  logic [WIDTH-1:0] WriteData,
    input  logic [4:0]       ReadRegister1,
    input  logic [4:0]       ReadRegister2,
    output logic [WIDTH-1:0] ReadData1,
    output logic [WIDTH-1:0] ReadData2
);

    localparam int ZERO_IDX = DEPTH - 1;

    logic [DEPTH-1:0] w_en;
    logic [WIDTH-1:0] r_regs  [DEPTH-1];
    logic [WIDTH-1:0] w_store [DEPTH];

    // One-hot write decoder; the zero register never receives an enable.
    always_comb begin
        w_en = {DEPTH{1'b0}};
        for (int i = 0; i < ZERO_IDX; i++) begin
            if (RegWrite && (WriteRegister == 5'(i))) begin
                w_en[i] = 1'b1;
            end else begin
                w_en[i] = 1'b0;
            end
        end
    end

    // Storage: one flop bank per writable register, loaded only when enabled.
    for (genvar g = 0; g < ZERO_IDX; g++) begin : g_reg
        // Register X<g>: async clear, load on its decoded enable, hold otherwise.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_regs[g] <= {WIDTH{1'b0}};
            end else if (w_en[g]) begin
                r_regs[g] <= WriteData;
            end else begin
                r_regs[g] <= r_regs[g];
            end
        end
        assign w_store[g] = r_regs[g];
    end

    assign w_store[ZERO_IDX] = {WIDTH{1'b0}};

    // Read port 1: the enable of the addressed register doubles as the bypass
    // select, since it is already qualified by RegWrite and excludes X31.
    always_comb begin
        ReadData1 = {WIDTH{1'b0}};
        if (!reset_n) begin
            ReadData1 = {WIDTH{1'b0}};
        end else if (w_en[ReadRegister1]) begin
            ReadData1 = WriteData;
        end else begin
            ReadData1 = w_store[ReadRegister1];
        end
    end

    // Read port 2: same structure as port 1, both ports may bypass at once.
    always_comb begin
        ReadData2 = {WIDTH{1'b0}};
        if (!reset_n) begin
            ReadData2 = {WIDTH{1'b0}};
        end else if (w_en[ReadRegister2]) begin
            ReadData2 = WriteData;
        end else begin
            ReadData2 = w_store[ReadRegister2];
        end
    end

endmodule

// File: tb/tb_regfile_write_decode.sv
// -----------------------------------------------------------------------------
// tb_regfile_write_decode
//   Directed, table-driven bench for regfile_write_decode. Vectors are applied
//   just after the falling edge, read ports are checked before the rising
//   edge, and each vector's write (if any) lands on that rising edge.
// -----------------------------------------------------------------------------
module tb_regfile_write_decode;

    logic        clk;
    logic        clk_en;
    logic        reset_n;
    logic        RegWrite;
    logic [4:0]  WriteRegister;
    logic [63:0] WriteData;
    logic [4:0]  ReadRegister1;
    logic [4:0]  ReadRegister2;
    logic [63:0] ReadData1;
    logic [63:0] ReadData2;

    int n_tests = 0;
    int n_fail  = 0;

    logic [63:0] model [32];

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [63:0] wd;
        logic [4:0]  ra1;
        logic [4:0]  ra2;
        logic [63:0] e1;
        logic [63:0] e2;
    } vec_t;

    localparam int NVEC = 16;
    vec_t vecs [NVEC];

    regfile_write_decode #(.WIDTH(64), .DEPTH(32)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .RegWrite      (RegWrite),
        .WriteRegister (WriteRegister),
        .WriteData     (WriteData),
        .ReadRegister1 (ReadRegister1),
        .ReadRegister2 (ReadRegister2),
        .ReadData1     (ReadData1),
        .ReadData2     (ReadData2)
    );

    initial clk = 1'b0;
    always #5 if (clk_en) clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [4:0] wa, input logic [63:0] wd,
                         input logic [4:0] ra1, input logic [4:0] ra2);
        RegWrite      = we;
        WriteRegister = wa;
        WriteData     = wd;
        ReadRegister1 = ra1;
        ReadRegister2 = ra2;
    endtask

    // Compare every address on both ports against the bench model.
    task automatic sweep(input string name);
        for (int a = 0; a < 32; a++) begin
            ReadRegister1 = 5'(a);
            ReadRegister2 = 5'(31 - a);
            #1;
            check({name, "_p1"}, ReadData1, model[a]);
            check({name, "_p2"}, ReadData2, model[31 - a]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        clk_en  = 1'b0;
        reset_n = 1'b1;
        drive(1'b0, 5'd0, 64'd0, 5'd0, 5'd0);
        for (int i = 0; i < 32; i++) model[i] = 64'd0;

        vecs[0]  = '{1'b1, 5'd0,  64'h0000_0000_0000_0001, 5'd0,  5'd5,  64'h1, 64'h0};
        vecs[1]  = '{1'b1, 5'd5,  64'hDEAD_BEEF_CAFE_F00D, 5'd0,  5'd5,  64'h1, 64'hDEAD_BEEF_CAFE_F00D};
        vecs[2]  = '{1'b1, 5'd30, 64'hFFFF_FFFF_FFFF_FFFF, 5'd5,  5'd30, 64'hDEAD_BEEF_CAFE_F00D, 64'hFFFF_FFFF_FFFF_FFFF};
        vecs[3]  = '{1'b0, 5'd30, 64'h0,                   5'd5,  5'd30, 64'hDEAD_BEEF_CAFE_F00D, 64'hFFFF_FFFF_FFFF_FFFF};
        vecs[4]  = '{1'b0, 5'd0,  64'h0,                   5'd0,  5'd1,  64'h1, 64'h0};
        vecs[5]  = '{1'b1, 5'd31, 64'h1234,                5'd31, 5'd31, 64'h0, 64'h0};
        vecs[6]  = '{1'b0, 5'd31, 64'h1234,                5'd31, 5'd31, 64'h0, 64'h0};
        vecs[7]  = '{1'b1, 5'd7,  64'hAAAA,                5'd7,  5'd6,  64'hAAAA, 64'h0};
        vecs[8]  = '{1'b1, 5'd7,  64'h5555,                5'd7,  5'd7,  64'h5555, 64'h5555};
        vecs[9]  = '{1'b1, 5'd7,  64'hAAAA,                5'd7,  5'd5,  64'hAAAA, 64'hDEAD_BEEF_CAFE_F00D};
        vecs[10] = '{1'b0, 5'd7,  64'h5555,                5'd7,  5'd7,  64'hAAAA, 64'hAAAA};
        vecs[11] = '{1'b0, 5'd0,  64'h0,                   5'd7,  5'd7,  64'hAAAA, 64'hAAAA};
        vecs[12] = '{1'b1, 5'd4,  64'h11,                  5'd4,  5'd3,  64'h11, 64'h0};
        vecs[13] = '{1'b1, 5'd4,  64'h22,                  5'd4,  5'd4,  64'h22, 64'h22};
        vecs[14] = '{1'b0, 5'd4,  64'h33,                  5'd4,  5'd4,  64'h22, 64'h22};
        vecs[15] = '{1'b1, 5'd2,  64'h3,                   5'd2,  5'd30, 64'h3, 64'hFFFF_FFFF_FFFF_FFFF};

        // Reset pulse with the clock stopped, checked during and after.
        #5 reset_n = 1'b0;
        #2;
        check("reset_low_p1", ReadData1, 64'h0);
        check("reset_low_p2", ReadData2, 64'h0);
        #3 reset_n = 1'b1;
        #1;
        sweep("reset_sweep");

        clk_en = 1'b1;

        // Table-driven vectors: check before the edge, write lands on it.
        for (int v = 0; v < NVEC; v++) begin
            @(negedge clk);
            drive(vecs[v].we, vecs[v].wa, vecs[v].wd, vecs[v].ra1, vecs[v].ra2);
            #1;
            check($sformatf("vec%0d_p1", v), ReadData1, vecs[v].e1);
            check($sformatf("vec%0d_p2", v), ReadData2, vecs[v].e2);
            if (vecs[v].we && vecs[v].wa != 5'd31) model[vecs[v].wa] = vecs[v].wd;
        end
        @(negedge clk);
        drive(1'b0, 5'd0, 64'd0, 5'd0, 5'd0);
        sweep("after_vectors");

        // Enable gating: RegWrite low across every address with all-ones data.
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            drive(1'b0, 5'(i), 64'hFFFF_FFFF_FFFF_FFFF, 5'(i), 5'(31 - i));
            #1;
            check("gate_p1", ReadData1, model[i]);
            check("gate_p2", ReadData2, model[31 - i]);
        end
        @(negedge clk);
        sweep("after_gating");

        // Reset mid-operation.
        @(negedge clk);
        drive(1'b1, 5'd3, 64'h77, 5'd3, 5'd5);
        @(posedge clk);
        #1;
        drive(1'b0, 5'd3, 64'h0, 5'd3, 5'd3);
        #1;
        check("x3_before_reset", ReadData1, 64'h77);
        reset_n = 1'b0;
        #1;
        check("x3_async_clear_p1", ReadData1, 64'h0);
        check("x3_async_clear_p2", ReadData2, 64'h0);
        drive(1'b1, 5'd3, 64'h99, 5'd3, 5'd3);
        #1;
        check("bypass_in_reset", ReadData1, 64'h0);
        @(posedge clk);
        #1;
        check("write_in_reset", ReadData2, 64'h0);
        @(negedge clk);
        reset_n = 1'b1;
        drive(1'b0, 5'd3, 64'h0, 5'd3, 5'd5);
        #1;
        check("x3_after_reset", ReadData1, 64'h0);
        check("x5_after_reset", ReadData2, 64'h0);
        @(negedge clk);
        drive(1'b1, 5'd3, 64'h99, 5'd3, 5'd5);
        #1;
        check("x3_post_reset_bypass", ReadData1, 64'h99);
        @(negedge clk);
        drive(1'b0, 5'd0, 64'h0, 5'd3, 5'd3);
        #1;
        check("x3_post_reset_stored", ReadData1, 64'h99);
        for (int i = 0; i < 32; i++) model[i] = 64'd0;
        model[3] = 64'h99;
        sweep("final");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
